// File: rtl/id_ex_stage.sv
// Decode/operand-fetch stage: turns a fetched instruction into an execute-ready
// bundle held in a single output register, with writeback bypass on the
// operand values both at capture time and while the entry is stalled.
module id_ex_stage #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // upstream handshake
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [31:0]           in_pc,
    // register file read port (asynchronous data)
    output logic [4:0]            rf_a1,
    output logic [4:0]            rf_a2,
    input  logic [DATA_WIDTH-1:0] rf_rd1,
    input  logic [DATA_WIDTH-1:0] rf_rd2,
    // writeback port, same as the register file write port
    input  logic                  wb_we,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    // kill request from branch resolution
    input  logic                  flush,
    // downstream handshake and payload
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [DATA_WIDTH-1:0] out_rs1_val,
    output logic [DATA_WIDTH-1:0] out_rs2_val,
    output logic [31:0]           out_imm,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic [6:0]            out_opcode,
    output logic [2:0]            out_funct3,
    output logic                  out_funct7b5,
    output logic                  out_reg_we
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [6:0]            opcode;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [31:0]           imm;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic                  reg_we;
    logic                  capture;
    logic                  holding;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign rf_a1  = rs1;
    assign rf_a2  = rs2;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;
    assign holding  = out_valid && !out_ready;

    // Immediate generation by instruction format.
    always_comb begin
        imm = 32'h0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR:
                imm = {{20{in_instr[31]}}, in_instr[31:20]};
            OP_STORE:
                imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OP_BRANCH:
                imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {in_instr[31:12], 12'h000};
            OP_JAL:
                imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
            default:
                imm = 32'h0;
        endcase
    end

    // Source operands: x0 reads zero, same-cycle writeback wins over the file.
    always_comb begin
        rs1_val = rf_rd1;
        rs2_val = rf_rd2;
        if (rs1 == 5'd0) begin
            rs1_val = '0;
        end else if (wb_we && (wb_rd == rs1)) begin
            rs1_val = wb_data;
        end
        if (rs2 == 5'd0) begin
            rs2_val = '0;
        end else if (wb_we && (wb_rd == rs2)) begin
            rs2_val = wb_data;
        end
    end

    assign reg_we = (rd != 5'd0) && (opcode != OP_STORE) && (opcode != OP_BRANCH);

    // Output register: reset > flush > capture > stalled hold (with bypass) > drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_pc       <= 32'h0;
            out_rs1_val  <= '0;
            out_rs2_val  <= '0;
            out_imm      <= 32'h0;
            out_rs1      <= 5'd0;
            out_rs2      <= 5'd0;
            out_rd       <= 5'd0;
            out_opcode   <= 7'd0;
            out_funct3   <= 3'd0;
            out_funct7b5 <= 1'b0;
            out_reg_we   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_rs1_val  <= rs1_val;
            out_rs2_val  <= rs2_val;
            out_imm      <= imm;
            out_rs1      <= rs1;
            out_rs2      <= rs2;
            out_rd       <= rd;
            out_opcode   <= opcode;
            out_funct3   <= in_instr[14:12];
            out_funct7b5 <= in_instr[30];
            out_reg_we   <= reg_we;
        end else if (holding) begin
            if (wb_we && (wb_rd != 5'd0) && (wb_rd == out_rs1)) begin
                out_rs1_val <= wb_data;
            end
            if (wb_we && (wb_rd != 5'd0) && (wb_rd == out_rs2)) begin
                out_rs2_val <= wb_data;
            end
        end else if (out_valid) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_id_ex_stage;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc;
    logic [4:0]    rf_a1;
    logic [4:0]    rf_a2;
    logic [DW-1:0] rf_rd1;
    logic [DW-1:0] rf_rd2;
    logic          wb_we;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [DW-1:0] out_rs1_val;
    logic [DW-1:0] out_rs2_val;
    logic [31:0]   out_imm;
    logic [4:0]    out_rs1;
    logic [4:0]    out_rs2;
    logic [4:0]    out_rd;
    logic [6:0]    out_opcode;
    logic [2:0]    out_funct3;
    logic          out_funct7b5;
    logic          out_reg_we;

    id_ex_stage #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7b5(out_funct7b5), .out_reg_we(out_reg_we)
    );

    always #5 clk = ~clk;

    // Expected contents of the single output entry.
    typedef struct packed {
        logic          valid;
        logic [31:0]   pc;
        logic [DW-1:0] v1;
        logic [DW-1:0] v2;
        logic [31:0]   imm;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    rd;
        logic [6:0]    op;
        logic [2:0]    f3;
        logic          f7b5;
        logic          we;
    } ent_t;

    ent_t          m;
    logic [DW-1:0] regs [32];
    int            vectors = 0;
    int            miscompares = 0;
    bit            chk_en = 1'b0;

    // Register file behaviour; x0 holds junk to prove the DUT forces zero.
    assign rf_rd1 = regs[rf_a1];
    assign rf_rd2 = regs[rf_a2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Immediate from the format rules, built by shifting and masking.
    function automatic logic [31:0] imm_of(input logic [31:0] ins);
        logic [31:0] fill;
        logic [31:0] r;
        fill = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: r = (fill << 12) | (ins >> 20);
            7'h23: r = (fill << 12) | ((ins >> 25) << 5) | ((ins >> 7) & 32'h1F);
            7'h63: r = (fill << 12) | (((ins >> 7) & 32'h1) << 11)
                     | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
            7'h37, 7'h17: r = ins & 32'hFFFF_F000;
            7'h6F: r = (fill << 20) | (ins & 32'h000F_F000)
                     | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Operand value a consumer must see at capture time.
    function automatic logic [DW-1:0] src_of(input logic [4:0] idx);
        if (idx == 5'd0) return '0;
        if (wb_we && wb_rd == idx) return wb_data;
        return regs[idx];
    endfunction

    // Behavioural model of the stage plus the register file.
    always @(posedge clk) begin
        if (!rst_n) begin
            m <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= DW'(i * 32'h1111 + 32'hA0);
        end else begin
            if (flush) begin
                m.valid <= 1'b0;
            end else if (in_valid && (!m.valid || out_ready)) begin
                m.valid <= 1'b1;
                m.pc    <= in_pc;
                m.rs1   <= 5'((in_instr >> 15) & 32'h1F);
                m.rs2   <= 5'((in_instr >> 20) & 32'h1F);
                m.rd    <= 5'((in_instr >> 7) & 32'h1F);
                m.op    <= 7'(in_instr & 32'h7F);
                m.f3    <= 3'((in_instr >> 12) & 32'h7);
                m.f7b5  <= in_instr[30];
                m.imm   <= imm_of(in_instr);
                m.v1    <= src_of(5'((in_instr >> 15) & 32'h1F));
                m.v2    <= src_of(5'((in_instr >> 20) & 32'h1F));
                m.we    <= (((in_instr >> 7) & 32'h1F) != 0)
                           && (in_instr[6:0] != 7'h23) && (in_instr[6:0] != 7'h63);
            end else if (m.valid && !out_ready) begin
                if (wb_we && wb_rd != 0 && wb_rd == m.rs1) m.v1 <= wb_data;
                if (wb_we && wb_rd != 0 && wb_rd == m.rs2) m.v2 <= wb_data;
            end else begin
                m.valid <= 1'b0;
            end
            if (wb_we && wb_rd != 0) regs[wb_rd] <= wb_data;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(!flush && (!m.valid || out_ready)));
            chk("rf_a1", 64'(rf_a1), 64'(in_instr[19:15]));
            chk("rf_a2", 64'(rf_a2), 64'(in_instr[24:20]));
            chk("out_valid", 64'(out_valid), 64'(m.valid));
            if (m.valid) begin
                chk("out_pc", 64'(out_pc), 64'(m.pc));
                chk("out_rs1_val", 64'(out_rs1_val), 64'(m.v1));
                chk("out_rs2_val", 64'(out_rs2_val), 64'(m.v2));
                chk("out_imm", 64'(out_imm), 64'(m.imm));
                chk("out_rs1", 64'(out_rs1), 64'(m.rs1));
                chk("out_rs2", 64'(out_rs2), 64'(m.rs2));
                chk("out_rd", 64'(out_rd), 64'(m.rd));
                chk("out_opcode", 64'(out_opcode), 64'(m.op));
                chk("out_funct3", 64'(out_funct3), 64'(m.f3));
                chk("out_funct7b5", 64'(out_funct7b5), 64'(m.f7b5));
                chk("out_reg_we", 64'(out_reg_we), 64'(m.we));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        wb_we     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
    endtask

    logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h33, 7'h33, 7'h0F, 7'h73};

    initial begin
        logic [31:0] ins;
        rst_n = 1'b0;
        idle();
        in_instr = 32'h0;
        in_pc    = 32'h0;
        wb_rd    = 5'd0;
        wb_data  = '0;
        step();
        step();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_imm", 64'(out_imm), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // addi x5,x0,-1
        in_valid = 1'b1; in_instr = 32'hFFF0_0293; in_pc = 32'h100;
        step();
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_rd", 64'(out_rd), 64'd5);
        chk("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
        chk("addi_rs1_val", 64'(out_rs1_val), 64'd0);
        chk("addi_reg_we", 64'(out_reg_we), 64'd1);
        chk("addi_pc", 64'(out_pc), 64'h100);

        // x1 := 7, then add x3,x1,x2 while x1 is being rewritten with 42
        in_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
        step();
        in_valid = 1'b1; in_instr = 32'h0020_81B3; in_pc = 32'h104; wb_data = 32'd42;
        step();
        chk("bypass_rs1_val", 64'(out_rs1_val), 64'd42);
        chk("bypass_rs2_val", 64'(out_rs2_val), 64'h22C2);
        chk("bypass_rd", 64'(out_rd), 64'd3);

        // add x6,x4,x5 then stall three cycles with x4 written mid-stall
        wb_we = 1'b0; in_instr = 32'h0052_0333; in_pc = 32'h108;
        step();
        chk("hold_cap_rs1", 64'(out_rs1), 64'd4);
        in_instr = 32'h0000_0013; in_pc = 32'h10C; out_ready = 1'b0;
        #1 chk("hold_in_ready0", 64'(in_ready), 64'd0);
        step();
        chk("hold_in_ready1", 64'(in_ready), 64'd0);
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h55;
        step();
        wb_we = 1'b0;
        chk("hold_in_ready2", 64'(in_ready), 64'd0);
        step();
        chk("hold_rs1_val", 64'(out_rs1_val), 64'h55);
        chk("hold_rs2_val", 64'(out_rs2_val), 64'h55F5);
        chk("hold_rd", 64'(out_rd), 64'd6);
        chk("hold_pc", 64'(out_pc), 64'h108);
        chk("hold_valid", 64'(out_valid), 64'd1);

        // flush over a held entry with a new instruction offered
        flush = 1'b1;
        #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("flush_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("flush_no_capture", 64'(out_valid), 64'd0);

        // beq x0,x0,-4 ; sw x5,-4(x2) ; lui x1,0x12345
        in_valid = 1'b1; in_instr = 32'hFE00_0EE3; in_pc = 32'h200;
        step();
        chk("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
        chk("beq_reg_we", 64'(out_reg_we), 64'd0);
        in_instr = 32'hFE51_2E23; in_pc = 32'h204;
        step();
        chk("sw_imm", 64'(out_imm), 64'hFFFF_FFFC);
        chk("sw_reg_we", 64'(out_reg_we), 64'd0);
        in_instr = 32'h1234_50B7; in_pc = 32'h208;
        step();
        chk("lui_imm", 64'(out_imm), 64'h1234_5000);
        chk("lui_reg_we", 64'(out_reg_we), 64'd1);

        // addi x7,x0,5 with writes to x0 at capture and during a stall, then reset
        in_instr = 32'h0050_0393; in_pc = 32'h20C;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
        step();
        chk("x0_cap_rs1_val", 64'(out_rs1_val), 64'd0);
        chk("x0_cap_imm", 64'(out_imm), 64'd5);
        in_valid = 1'b0; out_ready = 1'b0; wb_data = 32'h999;
        step();
        chk("x0_hold_rs1_val", 64'(out_rs1_val), 64'd0);
        chk("x0_hold_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0; wb_we = 1'b0; in_valid = 1'b1;
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_rd", 64'(out_rd), 64'd0);
        chk("rst_rs1_val", 64'(out_rs1_val), 64'd0);
        chk("rst_opcode", 64'(out_opcode), 64'd0);
        chk("rst_reg_we", 64'(out_reg_we), 64'd0);
        rst_n = 1'b1;
        idle();
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 11)];
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
            in_instr  = ins;
            in_pc     = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 9) == 0);
            wb_we     = ($urandom_range(0, 1) == 1);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            rst_n     = ($urandom_range(0, 99) != 0);
            step();
        end

        rst_n = 1'b1;
        idle();
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
